// File: rtl/hack_ram_loader.sv
// Boot loader: streams a length-prefixed image into RAM16K, then hands the RAM write port to the CPU.
// Define RAM_LOADER_CHECKSUM_EN to require a trailing 16-bit sum word after the data.
module hack_ram_loader #(
    parameter logic [13:0] START_ADDR = 14'd0
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] cpu_in,
    input  logic        cpu_load,
    input  logic [13:0] cpu_address,
    output logic [15:0] ram_in,
    output logic        ram_load,
    output logic [13:0] ram_address,
    output logic        busy,
    output logic        done,
    output logic        error
);

`ifdef RAM_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {HDR, DATA, CSUM, RUN} state_t;
    localparam state_t AFTER_DATA = CSUM;
`else
    typedef enum logic [1:0] {HDR, DATA, RUN} state_t;
    localparam state_t AFTER_DATA = RUN;
`endif

    // Largest legal count: the image must end at or before the top of RAM.
    localparam logic [15:0] MAX_CNT = 16'd16384 - {2'b00, START_ADDR};

    state_t      state_q, state_d;
    logic [13:0] idx_q, idx_d;
    logic [14:0] count_q, count_d;
    logic        error_q, error_d;
    logic        done_q, done_d;
    logic        xfer;
`ifdef RAM_LOADER_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;
`endif

    assign xfer  = s_valid && s_ready;
    assign busy  = !done_q;
    assign done  = done_q;
    assign error = error_q;

    always_comb begin
        s_ready = !reset && (state_q != RUN);
        if (state_q == RUN) begin
            ram_in      = cpu_in;
            ram_load    = cpu_load && !reset;
            ram_address = cpu_address;
        end else begin
            ram_in      = s_data;
            ram_load    = (state_q == DATA) && s_valid && !reset;
            ram_address = START_ADDR + idx_q;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        error_d = error_q;
`ifdef RAM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            HDR: if (xfer) begin
                count_d = s_data[14:0];
                idx_d   = '0;
`ifdef RAM_LOADER_CHECKSUM_EN
                sum_d   = '0;
`endif
                if (s_data[15] || ({1'b0, s_data[14:0]} > MAX_CNT)) begin
                    error_d = 1'b1;
                    state_d = RUN;
                end else if (s_data[14:0] == '0) begin
                    state_d = AFTER_DATA;
                end else begin
                    state_d = DATA;
                end
            end
            DATA: if (xfer) begin
                idx_d = idx_q + 14'd1;
`ifdef RAM_LOADER_CHECKSUM_EN
                sum_d = sum_q + s_data;
`endif
                if (({1'b0, idx_q} + 15'd1) == count_q) state_d = AFTER_DATA;
            end
`ifdef RAM_LOADER_CHECKSUM_EN
            CSUM: if (xfer) begin
                if (s_data != sum_q) error_d = 1'b1;
                state_d = RUN;
            end
`endif
            default: ;
        endcase
        done_d = (state_d == RUN);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= HDR;
            idx_q   <= '0;
            count_q <= '0;
            error_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef RAM_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            error_q <= error_d;
            done_q  <= done_d;
`ifdef RAM_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_hack_ram_loader.sv
// Bench for hack_ram_loader: two instances (START_ADDR 0 and 0x3FF0) share one stream and
// are checked against expected write lists and a RAM16K array model.
module tb_hack_ram_loader;

`ifdef RAM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        reset, s_valid, cpu_load;
    logic [15:0] s_data, cpu_in;
    logic [13:0] cpu_address;
    logic        s_ready [2];
    logic        ram_load[2];
    logic        busy    [2];
    logic        done    [2];
    logic        err     [2];
    logic [15:0] ram_in  [2];
    logic [13:0] ram_addr[2];

    int          sa[2] = '{0, 'h3FF0};

    hack_ram_loader #(.START_ADDR(14'd0)) u0 (
        .CLK(CLK), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready[0]),
        .cpu_in(cpu_in), .cpu_load(cpu_load), .cpu_address(cpu_address),
        .ram_in(ram_in[0]), .ram_load(ram_load[0]), .ram_address(ram_addr[0]),
        .busy(busy[0]), .done(done[0]), .error(err[0]));

    hack_ram_loader #(.START_ADDR(14'h3FF0)) u1 (
        .CLK(CLK), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready[1]),
        .cpu_in(cpu_in), .cpu_load(cpu_load), .cpu_address(cpu_address),
        .ram_in(ram_in[1]), .ram_load(ram_load[1]), .ram_address(ram_addr[1]),
        .busy(busy[1]), .done(done[1]), .error(err[1]));

    // RAM16K stand-ins plus a log of writes made while each loader owns the RAM
    logic [15:0] mem [2][16384];
    logic [29:0] obs0[$];
    logic [29:0] obs1[$];
    int          stall_bad[2];

    always @(negedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            if (ram_load[k] === 1'b1) begin
                mem[k][ram_addr[k]] = ram_in[k];
                if (busy[k] !== 1'b0) begin
                    if (k == 0) obs0.push_back({ram_addr[k], ram_in[k]});
                    else        obs1.push_back({ram_addr[k], ram_in[k]});
                    if (!s_valid) stall_bad[k]++;
                end
            end
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (inst %0d): got %0h, expected %0h", name, k, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] hdr;
        bit          rnd;
        logic [15:0] d0, d1, d2;
        bit          gaps;
        logic [15:0] cs_xor;
        int          abort;
        bit          e0, e1;
    } vec_t;

    task automatic run_vec(input vec_t v, input int vi);
        int          cnt, i, nbad;
        bit          ok[2];
        bit          any, sent;
        logic [15:0] dat[$];
        logic [15:0] sum;
        logic [29:0] exp_w[$];
        logic [29:0] got;
        bit          exp_e;
        logic [15:0] tag;

        // reference: legality, image contents and running sum from plain arithmetic
        cnt = int'(v.hdr[14:0]);
        for (int k = 0; k < 2; k++) ok[k] = !v.hdr[15] && (cnt <= 16384 - sa[k]);
        any = ok[0] || ok[1];
        sum = 16'h0;
        for (int j = 0; j < cnt; j++) begin
            if (v.rnd) dat.push_back(16'($urandom));
            else       dat.push_back((j % 3 == 0) ? v.d0 : (j % 3 == 1) ? v.d1 : v.d2);
            sum = sum + dat[j];
        end

        // reset cycle with everything asserted that could leak a write
        @(posedge CLK); #1;
        reset = 1'b1; s_valid = 1'b1; s_data = 16'($urandom);
        cpu_load = 1'b1; cpu_in = 16'($urandom); cpu_address = 14'($urandom);
        obs0.delete(); obs1.delete(); stall_bad[0] = 0; stall_bad[1] = 0;
        @(negedge CLK);
        for (int k = 0; k < 2; k++) begin
            chk("s_ready_in_reset", k, 32'(s_ready[k]), 32'd0);
            chk("ram_load_in_reset", k, 32'(ram_load[k]), 32'd0);
        end

        // header
        @(posedge CLK); #1;
        reset = 1'b0; s_data = v.hdr; s_valid = 1'b1; cpu_load = 1'($urandom);
        @(negedge CLK);
        for (int k = 0; k < 2; k++) begin
            chk("busy_after_reset", k, 32'(busy[k]), 32'd1);
            chk("done_after_reset", k, 32'(done[k]), 32'd0);
            chk("error_after_reset", k, 32'(err[k]), 32'd0);
            chk("addr_after_reset", k, 32'(ram_addr[k]), 32'(sa[k]));
        end

        sent = 1'b0;
        if (any) begin
            i = 0;
            while (i < cnt) begin
                if (v.abort != 0 && i == v.abort) break;
                @(posedge CLK); #1;
                cpu_load = 1'($urandom); cpu_in = 16'($urandom); cpu_address = 14'($urandom);
                if (v.gaps && $urandom_range(0, 1) == 1) begin
                    s_valid = 1'b0; s_data = 16'($urandom);
                end else begin
                    s_valid = 1'b1; s_data = dat[i]; i++; sent = 1'b1;
                end
            end
            if (v.abort != 0) return;
            if (CSUM_EN) begin
                @(posedge CLK); #1;
                s_valid = 1'b1; s_data = sum ^ v.cs_xor; sent = 1'b1;
            end
            if (sent) begin
                @(negedge CLK);
                for (int k = 0; k < 2; k++) if (ok[k]) chk("done_before_last_edge", k, 32'(done[k]), 32'd0);
            end
        end

        @(posedge CLK); #1;
        s_valid = 1'b0; cpu_load = 1'b0;
        @(negedge CLK);
        for (int k = 0; k < 2; k++) begin
            exp_e = ((k == 0) ? v.e0 : v.e1) | (CSUM_EN && ok[k] && v.cs_xor != 16'h0);
            chk("done_after_load", k, 32'(done[k]), 32'd1);
            chk("busy_after_load", k, 32'(busy[k]), 32'd0);
            chk("error_after_load", k, 32'(err[k]), 32'(exp_e));
            exp_w.delete();
            if (ok[k]) for (int j = 0; j < cnt; j++) exp_w.push_back({14'(sa[k] + j), dat[j]});
            chk("write_count", k, 32'((k == 0) ? obs0.size() : obs1.size()), 32'(exp_w.size()));
            nbad = 0;
            for (int j = 0; j < exp_w.size(); j++) begin
                got = (k == 0) ? ((j < obs0.size()) ? obs0[j] : 30'h0) : ((j < obs1.size()) ? obs1[j] : 30'h0);
                if (got !== exp_w[j]) nbad++;
            end
            chk("write_addr_data", k, 32'(nbad), 32'd0);
            chk("write_while_stalled", k, 32'(stall_bad[k]), 32'd0);
        end

        // read the image back through the CPU pass-through
        for (int k = 0; k < 2; k++) begin
            if (!ok[k]) continue;
            for (int j = 0; j < cnt && j < 3; j++) begin
                @(posedge CLK); #1;
                cpu_load = 1'b0; cpu_address = 14'(sa[k] + j);
                @(negedge CLK);
                chk("readback", k, 32'(mem[k][ram_addr[k]]), 32'(dat[j]));
            end
        end

        // CPU write then read at address 5
        tag = 16'hBEEF ^ 16'(vi);
        @(posedge CLK); #1;
        cpu_load = 1'b1; cpu_address = 14'd5; cpu_in = tag;
        @(posedge CLK); #1;
        cpu_load = 1'b0; cpu_in = 16'($urandom);
        @(negedge CLK);
        for (int k = 0; k < 2; k++) begin
            chk("cpu_addr_passthru", k, 32'(ram_addr[k]), 32'd5);
            chk("cpu_write_readback", k, 32'(mem[k][ram_addr[k]]), 32'(tag));
        end
    endtask

    initial begin
        vec_t tbl[11];
        reset = 1'b1; s_valid = 1'b0; s_data = 16'h0;
        cpu_in = 16'h0; cpu_load = 1'b0; cpu_address = 14'h0;
        stall_bad[0] = 0; stall_bad[1] = 0;

        //            hdr       rnd d0        d1        d2        gaps cs_xor  abort e0 e1
        tbl[0]  = '{16'd3,     0, 16'h1111, 16'h2222, 16'h3333, 0, 16'h0,   0,  0, 0};
        tbl[1]  = '{16'd16,    1, 16'h0,    16'h0,    16'h0,    1, 16'h0,   0,  0, 0};
        tbl[2]  = '{16'd17,    1, 16'h0,    16'h0,    16'h0,    0, 16'h0,   0,  0, 1};
        tbl[3]  = '{16'h8001,  1, 16'h0,    16'h0,    16'h0,    0, 16'h0,   0,  1, 1};
        tbl[4]  = '{16'd100,   1, 16'h0,    16'h0,    16'h0,    0, 16'h0,   40, 0, 1};
        tbl[5]  = '{16'd2,     0, 16'hFFFF, 16'h0002, 16'h0,    0, 16'h0,   0,  0, 0};
        tbl[6]  = '{16'd2,     0, 16'hFFFF, 16'h0002, 16'h0,    1, 16'h1,   0,  0, 0};
        tbl[7]  = '{16'd0,     1, 16'h0,    16'h0,    16'h0,    0, 16'h0,   0,  0, 0};
        tbl[8]  = '{16'h4000,  1, 16'h0,    16'h0,    16'h0,    0, 16'h0,   0,  0, 1};
        tbl[9]  = '{16'h4001,  1, 16'h0,    16'h0,    16'h0,    0, 16'h0,   0,  1, 1};
        tbl[10] = '{16'd1,     1, 16'h0,    16'h0,    16'h0,    1, 16'h0,   0,  0, 0};

        repeat (2) @(posedge CLK);
        for (int vi = 0; vi < 11; vi++) run_vec(tbl[vi], vi);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hack_ram_loader.md
# hack_ram_loader

Boot-time loader placed directly upstream of `RAM16K_Optim`. After reset it accepts a length-prefixed stream of 16-bit words over a valid/ready handshake and writes them to consecutive RAM16K addresses. It then hands the RAM write port to the CPU as a pass-through. It owns the RAM's `in`/`load`/`address` inputs. RAM `out` goes straight to the CPU and is not routed through this block.

## Interface
- `START_ADDR`, default 0: first RAM address written; 14-bit value.
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `s_data`  in  16  stream word: header, then data, then the optional checksum.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  loader accepts a word this cycle. A transfer is `s_valid && s_ready`.
- `cpu_in`  in  16  CPU write data.
- `cpu_load`  in  1  CPU write enable.
- `cpu_address`  in  14  CPU address.
- `ram_in`  out  16  to RAM16K `in`.
- `ram_load`  out  1  to RAM16K `load`.
- `ram_address`  out  14  to RAM16K `address`.
- `busy`  out  1  loader owns the RAM; the CPU must be held in reset.
- `done`  out  1  load finished; CPU pass-through active.
- `error`  out  1  bad header or checksum mismatch; sticky until reset.

## Operation
- **States:** HDR, DATA, CSUM (only with the macro), RUN.
- **HDR:** `s_ready`=1.
  - On transfer, latch `count` = `s_data[14:0]` and clear `idx` and `sum`.
  - Bit 15 set, or `count > 16384 − START_ADDR`: set `error`, go to RUN, no writes.
  - `count` == 0: go to RUN (or to CSUM with the macro).
  - Otherwise go to DATA.
- **DATA:** `s_ready`=1.
  - `ram_address` = `START_ADDR + idx` (14-bit).
  - `ram_in` = `s_data`.
  - `ram_load` = `s_valid`. The write lands at the same edge as the transfer.
  - On transfer: `idx++` and `sum += s_data` (mod 2^16).
  - After the transfer with `idx == count−1`, go to RUN (or CSUM with the macro).
- **RUN:** `s_ready`=0.
  - `ram_in`/`ram_load`/`ram_address` = `cpu_in`/`cpu_load`/`cpu_address`, purely combinational with no added latency.
  - RUN stays until reset.
- **Outside RUN:**
  - `cpu_*` inputs are ignored.
  - `ram_load` is 0 except on DATA transfers.
  - `ram_in` = `s_data`.
  - `ram_address` = `START_ADDR + idx`.
- **Address arithmetic:** never wraps, because the header check guarantees `START_ADDR + count ≤ 16384`.
- **Stalls:** `s_valid` low in DATA holds all state and keeps `ram_load` at 0.

## Timing
- **Reset values:** state HDR, `idx`=0, `count`=0, `sum`=0, `error`=0, `done`=0, `busy`=1.
  - `s_ready` is 0 in any cycle where `reset` is high.
  - `ram_load` is 0 in any cycle where `reset` is high.
- **Reset mid-load:** abandons the transfer and returns to HDR. RAM contents already written are not cleared.
- **Handshake and write latency:** one word per cycle maximum. A word is written to RAM 0 cycles after its handshake, at the same edge.
- `done`/`busy` are registered. They change on the edge after the final transfer: `done`=1 and `busy`=0 from the next cycle.
- An N-word load with continuous `s_valid` takes N+1 transfer cycles (N+2 with the macro). `done` rises on the following cycle.
- `error` is set on the same edge that enters RUN, and is visible together with `done`.

## Configuration
- `RAM_LOADER_CHECKSUM_EN` defined:
  - After DATA (or directly from HDR when `count`==0), the loader enters CSUM with `s_ready`=1.
  - One more word is accepted and compared with `sum`. A mismatch sets `error`.
  - Then RUN. The checksum word is never written to RAM.
- Undefined: no CSUM state and no `sum` register. DATA goes directly to RUN.

## Test plan
- **Basic load:** `START_ADDR`=0; stream header 3, then data 0x1111, 0x2222, 0x3333 with continuous valid. Required:
  - `ram_load` pulses at addresses 0, 1, 2.
  - `done`=1 one cycle after the last transfer.
  - Reading back RAM16K through CPU pass-through gives 0x1111, 0x2222, 0x3333.
- **Backpressure/gaps:** `START_ADDR`=0x3FF0; header 16, with `s_valid` toggled randomly. Required:
  - Exactly 16 writes, at addresses 0x3FF0–0x3FFF.
  - No write in any cycle where `s_valid` is low.
  - `error`=0.
- **Bad header:** `START_ADDR`=0x3FF0; header 17, or 0x8001. Required:
  - `error`=1, `done`=1, and zero RAM writes.
  - CPU write of 0xBEEF to address 5, then read-back, returns 0xBEEF.
- **Reset mid-load:** header 100; assert `reset` after 40 data words. Required:
  - `ram_load`=0 and `s_ready`=0 in the reset cycle.
  - The loader restarts in HDR.
  - A new header 2 writes to addresses 0–1.
- **Checksum (macro defined):**
  - Header 2, data 0xFFFF, 0x0002, checksum 0x0001: `error`=0.
  - The same with checksum 0x0000: `error`=1.
  - In both cases only 2 RAM writes occur.
- **Zero length:** header 0. Required: RUN on the next edge, no writes, `error`=0. With the macro defined, a checksum of 0x0000 is also required.
